// File: rtl/exi_capture_buf.sv
// -----------------------------------------------------------------------------
// exi_capture_buf
//
// Frame-aware capture FIFO between the EXI-side SPI slave and the RPi-side
// command handler. Each received frame is stored in a byte ring as a one-byte
// length header followed by its payload. The read side only sees bytes up to
// commit_ptr, so a partially received frame is never visible. A frame that
// does not fit (ring full or payload longer than MAX_LEN) is dropped as a
// whole and counted in a saturating counter.
//
// Ports:
//   clk                  system clock
//   rst_n                asynchronous active-low reset
//   in_frame_start_i     pulse: chip-select asserted
//   in_frame_end_i       pulse: chip-select deasserted
//   in_valid_i           pulse: in_byte_i holds a received byte
//   in_byte_i    [7:0]   received byte
//   rd_pop_i             request the next committed byte
//   rd_data_o    [7:0]   popped byte (registered)
//   rd_valid_o           rd_data_o valid for one cycle
//   rd_empty_o           no committed bytes available
//   rd_level_o   [DL:0]  number of committed bytes available
//   frames_dropped_o     saturating count of dropped frames
//   busy_o               capture state machine not idle
// -----------------------------------------------------------------------------
module exi_capture_buf #(
    parameter int DEPTH_LOG2 = 8,
    parameter int MAX_LEN    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_frame_start_i,
    input  logic                  in_frame_end_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_byte_i,
    input  logic                  rd_pop_i,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    output logic                  rd_empty_o,
    output logic [DEPTH_LOG2:0]   rd_level_o,
    output logic [7:0]            frames_dropped_o,
    output logic                  busy_o
);

    localparam int              PW      = DEPTH_LOG2 + 1;
    localparam int              DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0]   DEPTH_C = PW'(DEPTH);
    localparam logic [7:0]      LEN_MAX = 8'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DISCARD = 2'd2,
        ST_CLOSE   = 2'd3
    } state_t;

    // Saturating add used by the dropped-frame counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {7'd0, b};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_q, wr_d;
    logic [PW-1:0]           hdr_q, hdr_d;
    logic [PW-1:0]           commit_q, commit_d;
    logic [PW-1:0]           rd_q;
    logic [7:0]              len_q, len_d;
    logic                    pend_q, pend_d;
    logic [7:0]              drop_cnt_q;
    logic [7:0]              rd_data_q;
    logic                    rd_valid_q;
    logic [7:0]              ring_q [0:DEPTH-1];

    logic                    full_s;
    logic                    commit_full_s;
    logic [PW-1:0]           rd_level_s;
    logic                    rd_fire_s;
    logic                    byte_drop_s;
    logic [1:0]              drop_inc_s;
    logic                    mem_we_s;
    logic [DEPTH_LOG2-1:0]   mem_waddr_s;
    logic [7:0]              mem_wdata_s;
    state_t                  start_state_s;
    logic [PW-1:0]           start_wr_s;
    logic                    start_drop_s;

    assign full_s        = ((wr_q - rd_q) == DEPTH_C);
    // A (re)start always begins from the last committed point, so fullness is
    // judged there; this also covers the restart after a missing frame end.
    assign commit_full_s = ((commit_q - rd_q) == DEPTH_C);
    assign rd_level_s    = commit_q - rd_q;
    assign rd_fire_s     = rd_pop_i && (rd_level_s != '0);

    // Outcome of a frame start: reserve the header slot or drop the frame.
    assign start_state_s = commit_full_s ? ST_DISCARD : ST_CAPTURE;
    assign start_wr_s    = commit_full_s ? commit_q : (commit_q + PW'(1));
    assign start_drop_s  = commit_full_s;

    // Next-state, pointer and ring-write control for the capture side.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        hdr_d       = hdr_q;
        commit_d    = commit_q;
        len_d       = len_q;
        pend_d      = pend_q;
        drop_inc_s  = 2'd0;
        byte_drop_s = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_q[DEPTH_LOG2-1:0];
        mem_wdata_s = in_byte_i;

        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                if (in_frame_start_i || pend_q) begin
                    state_d    = start_state_s;
                    wr_d       = start_wr_s;
                    hdr_d      = commit_q;
                    len_d      = 8'd0;
                    drop_inc_s = {1'b0, start_drop_s};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CAPTURE: begin
                if (in_frame_start_i) begin
                    // Missing frame end: abandon the open frame and restart.
                    state_d    = start_state_s;
                    wr_d       = start_wr_s;
                    hdr_d      = commit_q;
                    len_d      = 8'd0;
                    drop_inc_s = 2'd1 + {1'b0, start_drop_s};
                end else begin
                    if (in_valid_i) begin
                        if (!full_s && (len_q < LEN_MAX)) begin
                            mem_we_s = 1'b1;
                            wr_d     = wr_q + PW'(1);
                            len_d    = len_q + 8'd1;
                        end else begin
                            byte_drop_s = 1'b1;
                            wr_d        = commit_q;
                            drop_inc_s  = 2'd1;
                        end
                    end else begin
                        byte_drop_s = 1'b0;
                    end
                    // A drop coinciding with the frame end has nothing left to discard.
                    if (in_frame_end_i) begin
                        state_d = byte_drop_s ? ST_IDLE : ST_CLOSE;
                    end else begin
                        state_d = byte_drop_s ? ST_DISCARD : ST_CAPTURE;
                    end
                end
            end

            ST_CLOSE: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = hdr_q[DEPTH_LOG2-1:0];
                mem_wdata_s = len_q;
                commit_d    = wr_q;
                state_d     = ST_IDLE;
                pend_d      = in_frame_start_i;
            end

            ST_DISCARD: begin
                if (in_frame_start_i) begin
                    state_d    = start_state_s;
                    wr_d       = start_wr_s;
                    hdr_d      = commit_q;
                    len_d      = 8'd0;
                    drop_inc_s = {1'b0, start_drop_s};
                end else if (in_frame_end_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                wr_d    = commit_q;
                pend_d  = 1'b0;
            end
        endcase
    end

    // Control state, pointers, counters and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_q       <= '0;
            hdr_q      <= '0;
            commit_q   <= '0;
            rd_q       <= '0;
            len_q      <= 8'd0;
            pend_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            hdr_q      <= hdr_d;
            commit_q   <= commit_d;
            len_q      <= len_d;
            pend_q     <= pend_d;
            drop_cnt_q <= sat_add8(drop_cnt_q, drop_inc_s);
            rd_valid_q <= rd_fire_s;
            if (rd_fire_s) begin
                rd_data_q <= ring_q[rd_q[DEPTH_LOG2-1:0]];
                rd_q      <= rd_q + PW'(1);
            end
        end
    end

    // Ring storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            ring_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign rd_data_o        = rd_data_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_level_o       = rd_level_s;
    assign rd_empty_o       = (rd_level_s == '0);
    assign frames_dropped_o = drop_cnt_q;
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exi_capture_buf.sv
module tb_exi_capture_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_frame_start;
    logic       in_frame_end;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       rd_pop;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_empty;
    logic [8:0] rd_level;
    logic [7:0] frames_dropped;
    logic       busy;

    logic [7:0] sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         exp_drop = 0;

    always #5 clk = ~clk;

    exi_capture_buf #(.DEPTH_LOG2(8), .MAX_LEN(255)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_frame_start_i (in_frame_start),
        .in_frame_end_i   (in_frame_end),
        .in_valid_i       (in_valid),
        .in_byte_i        (in_byte),
        .rd_pop_i         (rd_pop),
        .rd_data_o        (rd_data),
        .rd_valid_o       (rd_valid),
        .rd_empty_o       (rd_empty),
        .rd_level_o       (rd_level),
        .frames_dropped_o (frames_dropped),
        .busy_o           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p_start();
        in_frame_start = 1'b1;
        tick();
        in_frame_start = 1'b0;
    endtask

    task automatic p_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_byte  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic p_end();
        in_frame_end = 1'b1;
        tick();
        in_frame_end = 1'b0;
    endtask

    task automatic bump_drop();
        exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    endtask

    // Complete frame that must commit; scoreboard gets header + payload.
    task automatic send_frame(input int len, input logic [7:0] seed);
        logic [7:0] v;
        p_start();
        for (int i = 0; i < len; i++) begin
            v = seed + 8'(i);
            p_byte(v);
        end
        p_end();
        tick();
        sb_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            v = seed + 8'(i);
            sb_q.push_back(v);
        end
        chk("commit_level", 32'(rd_level), 32'(sb_q.size()));
    endtask

    task automatic pop_n(input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            rd_pop = 1'b1;
            tick();
            chk("pop_valid", 32'(rd_valid), 32'd1);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL pop_underflow: observed=0x%0h expected=none", rd_data);
            end else begin
                e = sb_q.pop_front();
                chk("pop_data", 32'(rd_data), 32'(e));
            end
        end
        rd_pop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_frame_start = 1'b0; in_frame_end = 1'b0;
        in_valid = 1'b0; in_byte = 8'h00; rd_pop = 1'b0;
        #12;
        chk("rst_data",  32'(rd_data), 32'h00);
        chk("rst_valid", 32'(rd_valid), 32'd0);
        chk("rst_empty", 32'(rd_empty), 32'd1);
        chk("rst_level", 32'(rd_level), 32'd0);
        chk("rst_drop",  32'(frames_dropped), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic frame A5 5A C3
        p_start();
        chk("t1_busy", 32'(busy), 32'd1);
        p_byte(8'hA5); p_byte(8'h5A); p_byte(8'hC3);
        p_end();
        chk("t1_level_close", 32'(rd_level), 32'd0);
        tick();
        chk("t1_level", 32'(rd_level), 32'd4);
        sb_q.push_back(8'h03); sb_q.push_back(8'hA5);
        sb_q.push_back(8'h5A); sb_q.push_back(8'hC3);
        pop_n(4);
        tick();
        chk("t1_empty", 32'(rd_empty), 32'd1);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
        chk("empty_pop_valid", 32'(rd_valid), 32'd0);

        // Zero-length frame
        send_frame(0, 8'h00);
        pop_n(1);

        // Ring nearly full: 250 committed, then an overflowing frame
        send_frame(249, 8'h10);
        p_start();
        for (int i = 0; i < 10; i++) p_byte(8'hB0 + 8'(i));
        p_end();
        tick();
        bump_drop();
        chk("t3_level", 32'(rd_level), 32'd250);
        chk("t3_drop", 32'(frames_dropped), 32'(exp_drop));
        chk("t3_busy", 32'(busy), 32'd0);
        pop_n(8);
        send_frame(3, 8'hC0);
        pop_n(246);
        chk("t3_empty", 32'(rd_empty), 32'd1);

        // 256-byte payload exceeds MAX_LEN and the ring
        p_start();
        for (int i = 0; i < 256; i++) p_byte(8'(i));
        p_end();
        tick();
        bump_drop();
        chk("t4_level", 32'(rd_level), 32'd0);
        chk("t4_drop", 32'(frames_dropped), 32'(exp_drop));

        // Restart mid-frame: only 01 33 commits
        p_start();
        p_byte(8'h11); p_byte(8'h22);
        p_start();
        p_byte(8'h33);
        p_end();
        tick();
        bump_drop();
        sb_q.push_back(8'h01); sb_q.push_back(8'h33);
        chk("t5_level", 32'(rd_level), 32'd2);
        chk("t5_drop", 32'(frames_dropped), 32'(exp_drop));
        pop_n(2);

        // Start arriving during CLOSE is held and served next
        p_start();
        p_byte(8'h77);
        p_end();
        p_start();
        tick();
        chk("t6_busy", 32'(busy), 32'd1);
        p_byte(8'h88);
        p_end();
        tick();
        sb_q.push_back(8'h01); sb_q.push_back(8'h77);
        sb_q.push_back(8'h01); sb_q.push_back(8'h88);
        chk("t6_level", 32'(rd_level), 32'd4);
        pop_n(4);

        // Largest frame fills the whole ring; further starts drop and saturate
        send_frame(255, 8'h01);
        chk("full_level", 32'(rd_level), 32'd256);
        for (int i = 0; i < 260; i++) begin
            p_start();
            bump_drop();
        end
        chk("sat_drop", 32'(frames_dropped), 32'(exp_drop));
        chk("sat_busy", 32'(busy), 32'd1);
        p_end();
        chk("sat_idle", 32'(busy), 32'd0);
        chk("sat_level", 32'(rd_level), 32'd256);
        pop_n(256);

        // Reset in the middle of a capture
        send_frame(3, 8'h40);
        p_start();
        for (int i = 0; i < 5; i++) p_byte(8'h50 + 8'(i));
        pop_n(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data",  32'(rd_data), 32'h00);
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_empty", 32'(rd_empty), 32'd1);
        chk("mid_rst_level", 32'(rd_level), 32'd0);
        chk("mid_rst_drop",  32'(frames_dropped), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        exp_drop = 0;
        tick();
        send_frame(2, 8'hE0);
        chk("post_rst_level", 32'(rd_level), 32'd3);
        pop_n(3);
        chk("post_rst_drop", 32'(frames_dropped), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exi_capture_buf.md
# exi_capture_buf

Frame-aware capture FIFO between the EXI-side SPI slave and the RPi-side command handler. Accepts received EXI bytes plus chip-select frame boundaries. Stores each frame in a 256-byte ring as a one-byte length header followed by the payload. Publishes only completed frames to the read side, so the RPi command path never sees a partial frame. A frame that does not fit is dropped whole and counted.

## Interface
- DEPTH_LOG2, 8, log2 of ring size in bytes (ring = 256 entries × 8 bit)
- MAX_LEN, 255, largest payload length accepted per frame (must fit in 8-bit header)

- clk  in  1  system clock (PLL 25 MHz domain)
- rst_n  in  1  asynchronous active-low reset
- in_frame_start  in  1  one-cycle pulse: EXI chip-select asserted
- in_frame_end  in  1  one-cycle pulse: EXI chip-select deasserted
- in_valid  in  1  one-cycle pulse: in_byte holds a received EXI byte
- in_byte  in  8  received byte
- rd_pop  in  1  request next committed byte
- rd_data  out  8  popped byte, registered
- rd_valid  out  1  rd_data valid, one cycle
- rd_empty  out  1  no committed bytes available
- rd_level  out  DEPTH_LOG2+1  committed bytes available
- frames_dropped  out  8  saturating count of dropped frames
- busy  out  1  state != IDLE

## Operation
- Pointers: wr_ptr, hdr_ptr, commit_ptr, rd_ptr, each DEPTH_LOG2+1 bits. Ring index = low DEPTH_LOG2 bits; wrap is natural modulo.
- used = wr_ptr − rd_ptr (modulo 2^(DEPTH_LOG2+1)). full = used == 2^DEPTH_LOG2.
- rd_level = commit_ptr − rd_ptr. rd_empty = (rd_level == 0).
- States: IDLE, CAPTURE, DISCARD, CLOSE.
- IDLE, on in_frame_start:
  - not full: hdr_ptr←wr_ptr, wr_ptr+1, len←0, go to CAPTURE.
  - full: frames_dropped+1, go to DISCARD.
  - in_valid and in_frame_end in IDLE are ignored.
- CAPTURE, on in_valid:
  - not full and len < MAX_LEN: write in_byte at wr_ptr, wr_ptr+1, len+1.
  - otherwise: wr_ptr←commit_ptr (rewind), frames_dropped+1, go to DISCARD.
- CAPTURE, on in_frame_end: go to CLOSE.
  - If in_valid arrives in the same cycle, the byte is written first under the normal rules.
  - If that byte triggers a drop, the state goes to IDLE, not DISCARD.
- CAPTURE, on in_frame_start (missing end): rewind to commit_ptr, frames_dropped+1, then restart per IDLE rules in the same cycle.
  - This restart uses wr_ptr = commit_ptr.
- CLOSE (exactly one cycle): write len at hdr_ptr, commit_ptr←wr_ptr, go to IDLE.
  - A zero-length frame commits a lone header byte 0x00.
  - An in_frame_start arriving during CLOSE is latched in a pending flag and processed in the following IDLE cycle.
- DISCARD: ignore in_valid. in_frame_end → IDLE. in_frame_start → treat as IDLE start.
- in_frame_start and in_valid in the same cycle: the byte is ignored.
- frames_dropped saturates at 0xFF.
- Read: rd_pop with !rd_empty reads ring[rd_ptr], rd_ptr+1, rd_valid=1 next cycle. rd_pop while rd_empty is ignored (rd_valid stays 0).
- Write and read may happen in the same cycle. Read never overtakes commit_ptr, and write never overtakes rd_ptr.

## Timing
- Reset (async, any state): all pointers 0, len 0, pending 0, state IDLE.
  - Outputs: rd_data 0x00, rd_valid 0, rd_empty 1, rd_level 0, frames_dropped 0, busy 0.
  - Ring contents are not reset. A frame in progress at reset is lost and not counted.
- Byte write: ring updated at the clock edge sampling in_valid.
- Commit: rd_level and rd_empty reflect the frame on the cycle after CLOSE, i.e. 2 edges after in_frame_end.
- Read latency: rd_data/rd_valid 1 cycle after rd_pop. Back-to-back pops sustain 1 byte/cycle.
- rd_level updates the cycle after a pop or a commit.
- busy is high from the edge after in_frame_start until the edge leaving CLOSE/DISCARD.

## Test plan
- Frame start, bytes A5 5A C3, end, then pop 4 times:
  - rd_level goes 0→4 two edges after end.
  - rd_data 03, A5, 5A, C3; rd_empty=1 after.
- Frame start, end with no bytes: rd_level=1, popped byte 0x00.
- Fill ring with 250 committed bytes, no pops. Start a frame and send 10 bytes.
  - Frame dropped, rd_level stays 250, frames_dropped=1.
  - The next 3-byte frame after 8 pops commits normally.
- Frame of 256 payload bytes (MAX_LEN=255): dropped at byte 256, frames_dropped=1, rd_level unchanged.
- Second in_frame_start mid-frame after 2 bytes, then 1 byte, end: only frame 01 xx is committed, frames_dropped=1.
- Assert rst_n low mid-CAPTURE after 5 bytes with 4 committed bytes: all outputs at reset values, rd_level=0.
  - A fresh frame afterwards commits at index 0.
